// File: rtl/img2col_pkg.sv
// Shared types and constants for the img2col processing-unit front end.
package img2col_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } loader_state_t;

  localparam int K_DEFAULT   = 5;
  localparam int WIN_WORDS   = K_DEFAULT * K_DEFAULT;
  localparam int REFILL_BASE = WIN_WORDS - K_DEFAULT;

  // Words loaded by a window: full K*K on a row's first window, one K-word column afterwards.
  function automatic int window_words(input int k, input bit refill);
    return refill ? k : k * k;
  endfunction

endpackage

// File: rtl/pu_adrs_gen.sv
// Register-file write address generator for one loader beat: two consecutive
// addresses from the window base, collapsing to a duplicate write on an odd tail.
module pu_adrs_gen
  import img2col_pkg::*;
#(
  parameter int KERNEL      = K_DEFAULT,
  parameter int ADDRESS_NUM = 5
) (
  input  logic                   round,
  input  logic [ADDRESS_NUM-1:0] beat,
  input  logic                   last,
  output logic [ADDRESS_NUM-1:0] adrs1,
  output logic [ADDRESS_NUM-1:0] adrs2,
  output logic                   odd_tail
);

  localparam logic [ADDRESS_NUM-1:0] BASE_REFILL = ADDRESS_NUM'(KERNEL * KERNEL - KERNEL);
  // K and K*K share parity, so both full loads and refills have an odd tail iff K is odd.
  localparam bit ODD_WORDS = (KERNEL % 2) == 1;

  always_comb begin
    odd_tail = last && ODD_WORDS;
    adrs1    = (round ? BASE_REFILL : '0) + (beat << 1);
    adrs2    = odd_tail ? adrs1 : adrs1 + ADDRESS_NUM'(1);
  end

endmodule

// File: rtl/pu_loader.sv
// Stream-to-register-file loader feeding the img2col PU, one row of K x K windows per cmd_start.
// Optional build macro PU_LOADER_PERF_EN adds a saturating stall_cnt output.
// Handshake: a beat transfers on a rising edge where s_valid && s_ready; s_ready is a
// registered copy of "state is LOAD" and never depends combinationally on s_valid.
module pu_loader
  import img2col_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int KERNEL      = K_DEFAULT,
  parameter int ADDRESS_NUM = 5,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                    clk,
  input  logic                    nrst,
  input  logic                    cmd_start,
  input  logic [CNT_WIDTH-1:0]    cfg_windows,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [2*DATA_WIDTH-1:0] s_data,
  input  logic                    pu_done,
  output logic                    start,
  output logic                    round,
  output logic                    wr_en,
  output logic [ADDRESS_NUM-1:0]  adrs_in1,
  output logic [ADDRESS_NUM-1:0]  adrs_in2,
  output logic [DATA_WIDTH-1:0]   new1,
  output logic [DATA_WIDTH-1:0]   new2,
  output logic                    busy,
  output logic                    row_done,
`ifdef PU_LOADER_PERF_EN
  output logic [31:0]             stall_cnt,
`endif
  output loader_state_t           dbg_state
);

  localparam int FULL_BEATS   = (window_words(KERNEL, 1'b0) + 1) / 2;
  localparam int REFILL_BEATS = (window_words(KERNEL, 1'b1) + 1) / 2;
  localparam logic [ADDRESS_NUM-1:0] FULL_LAST   = ADDRESS_NUM'(FULL_BEATS - 1);
  localparam logic [ADDRESS_NUM-1:0] REFILL_LAST = ADDRESS_NUM'(REFILL_BEATS - 1);

  loader_state_t          state, state_n;
  logic [CNT_WIDTH-1:0]   win_idx, win_idx_n;
  logic [CNT_WIDTH-1:0]   last_idx, last_idx_n;
  logic [ADDRESS_NUM-1:0] beat_idx, beat_idx_n;
  logic                   round_n;
  logic                   accept;
  logic                   last_beat;
  logic [ADDRESS_NUM-1:0] gen_adrs1, gen_adrs2;
  logic                   odd_tail;

  assign accept    = s_valid && s_ready;
  assign last_beat = beat_idx == (round ? REFILL_LAST : FULL_LAST);
  assign dbg_state = state;

  pu_adrs_gen #(
    .KERNEL      (KERNEL),
    .ADDRESS_NUM (ADDRESS_NUM)
  ) u_adrs_gen (
    .round    (round),
    .beat     (beat_idx),
    .last     (last_beat),
    .adrs1    (gen_adrs1),
    .adrs2    (gen_adrs2),
    .odd_tail (odd_tail)
  );

  always_comb begin
    state_n    = state;
    win_idx_n  = win_idx;
    last_idx_n = last_idx;
    beat_idx_n = beat_idx;
    round_n    = round;
    case (state)
      IDLE: if (cmd_start) begin
        state_n    = LOAD;
        last_idx_n = (cfg_windows == '0) ? '0 : cfg_windows - CNT_WIDTH'(1);
        win_idx_n  = '0;
        beat_idx_n = '0;
        round_n    = 1'b0;
      end
      LOAD: if (accept) begin
        if (last_beat) begin
          state_n    = WAIT;
          beat_idx_n = '0;
        end else begin
          beat_idx_n = beat_idx + ADDRESS_NUM'(1);
        end
      end
      WAIT: if (pu_done) begin
        if (win_idx == last_idx) begin
          state_n = DONE;
        end else begin
          state_n   = LOAD;
          win_idx_n = win_idx + CNT_WIDTH'(1);
          round_n   = 1'b1;
        end
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (nrst) begin
      state    <= IDLE;
      win_idx  <= '0;
      last_idx <= '0;
      beat_idx <= '0;
      round    <= 1'b0;
      s_ready  <= 1'b0;
      start    <= 1'b0;
      busy     <= 1'b0;
      row_done <= 1'b0;
      wr_en    <= 1'b0;
      adrs_in1 <= '0;
      adrs_in2 <= '0;
      new1     <= '0;
      new2     <= '0;
    end else begin
      state    <= state_n;
      win_idx  <= win_idx_n;
      last_idx <= last_idx_n;
      beat_idx <= beat_idx_n;
      round    <= round_n;
      s_ready  <= state_n == LOAD;
      start    <= (state_n == LOAD) && (state != LOAD);
      busy     <= state_n != IDLE;
      row_done <= state_n == DONE;
      wr_en    <= accept;
      if (accept) begin
        adrs_in1 <= gen_adrs1;
        adrs_in2 <= gen_adrs2;
        new1     <= s_data[DATA_WIDTH-1:0];
        new2     <= odd_tail ? s_data[DATA_WIDTH-1:0] : s_data[2*DATA_WIDTH-1:DATA_WIDTH];
      end
    end
  end

`ifdef PU_LOADER_PERF_EN
  always_ff @(posedge clk) begin
    if (nrst) begin
      stall_cnt <= '0;
    end else if (state == IDLE && cmd_start) begin
      stall_cnt <= '0;
    end else if (state == LOAD && !s_valid && stall_cnt != '1) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pu_loader.sv
// Directed bench for pu_loader: full loads, refills, gapped streams, ignored
// control pulses, mid-load reset and zero window count, with a write scoreboard.
module tb_pu_loader;
  import img2col_pkg::*;

  localparam int DW = 16;
  localparam int AW = 5;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          nrst = 1'b1;
  logic          cmd_start = 1'b0;
  logic [CW-1:0] cfg_windows = '0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [2*DW-1:0] s_data = '0;
  logic          pu_done = 1'b0;
  logic          start, round, wr_en, busy, row_done;
  logic [AW-1:0] adrs_in1, adrs_in2;
  logic [DW-1:0] new1, new2;
  loader_state_t dbg_state;
`ifdef PU_LOADER_PERF_EN
  logic [31:0]   stall_cnt;
`endif

  pu_loader #(.DATA_WIDTH(DW), .KERNEL(5), .ADDRESS_NUM(AW), .CNT_WIDTH(CW)) dut (
    .clk         (clk),
    .nrst        (nrst),
    .cmd_start   (cmd_start),
    .cfg_windows (cfg_windows),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_data      (s_data),
    .pu_done     (pu_done),
    .start       (start),
    .round       (round),
    .wr_en       (wr_en),
    .adrs_in1    (adrs_in1),
    .adrs_in2    (adrs_in2),
    .new1        (new1),
    .new2        (new2),
    .busy        (busy),
    .row_done    (row_done),
`ifdef PU_LOADER_PERF_EN
    .stall_cnt   (stall_cnt),
`endif
    .dbg_state   (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [2*AW+2*DW-1:0] exp_q[$];
  bit mon_en = 1'b0;
  int start_cnt = 0;
  int row_cnt = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    nrst = 1'b1;
    repeat (2) tick();
    nrst = 1'b0;
  endtask

  // scoreboard: every write must follow a handshake on the previous edge, in order
  initial begin
    logic hs;
    logic [2*AW+2*DW-1:0] e;
    forever begin
      @(negedge clk);
      hs = s_valid && s_ready && !nrst;
      @(posedge clk);
      #1;
      if (mon_en) begin
        check("wr_en_latency", wr_en, hs);
        if (start) start_cnt++;
        if (row_done) row_cnt++;
        if (wr_en) begin
          if (exp_q.size() == 0) begin
            check("wr_unexpected", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("wr_word", {adrs_in1, adrs_in2, new1, new2}, e);
          end
        end
      end
    end
  end

  // drive nsend of the window's beats; each beat preceded by gap idle cycles
  task automatic send_beats(input int nwords, input int nsend, input int base, input int gap);
    int nbeats;
    int a1, a2, budget;
    logic [DW-1:0] wa, wb;
    nbeats = (nwords + 1) / 2;
    for (int j = 0; j < nsend; j++) begin
      s_valid = 1'b0;
      repeat (gap) tick();
      wa = DW'($urandom);
      wb = DW'($urandom);
      s_data  = {wb, wa};
      s_valid = 1'b1;
      budget = 0;
      while (!s_ready && budget < 50) begin
        tick();
        budget++;
      end
      if (!s_ready) check("ready_timeout", 0, 1);
      a1 = base + 2 * j;
      if (j == nbeats - 1 && (nwords % 2) == 1)
        exp_q.push_back({AW'(a1), AW'(a1), wa, wa});
      else
        exp_q.push_back({AW'(a1), AW'(a1 + 1), wa, wb});
      tick();
    end
    s_valid = 1'b0;
  endtask

  task automatic run_row(input int cfg, input int gap, input bit noise);
    int nwin, nwords, base, s0, r0, beats_so_far;
    nwin = (cfg == 0) ? 1 : cfg;
    s0 = start_cnt;
    r0 = row_cnt;
    beats_so_far = 0;
    cfg_windows = CW'(cfg);
    cmd_start = 1'b1;
    tick();
    cmd_start = 1'b0;
    for (int w = 0; w < nwin; w++) begin
      check("win_start", start, 1);
      check("win_round", round, (w > 0) ? 1 : 0);
      check("win_ready", s_ready, 1);
      nwords = (w == 0) ? 25 : 5;
      base   = (w == 0) ? 0 : 20;
      if (noise) pu_done = 1'b1;
      send_beats(nwords, (nwords + 1) / 2, base, gap);
      beats_so_far += (nwords + 1) / 2;
      pu_done = 1'b0;
      check("ready_off", s_ready, 0);
      check("round_hold", round, (w > 0) ? 1 : 0);
      check("busy_wait", busy, 1);
`ifdef PU_LOADER_PERF_EN
      check("stall_cnt", stall_cnt, gap * beats_so_far);
`endif
      if (noise) begin
        cmd_start = 1'b1;
        tick();
        cmd_start = 1'b0;
        check("cmd_in_wait", dbg_state, WAIT);
        check("start_in_wait", start, 0);
      end
      repeat (2) tick();
      check("wait_hold", s_ready, 0);
      pu_done = 1'b1;
      tick();
      pu_done = 1'b0;
      if (w == nwin - 1) begin
        check("row_done_on", row_done, 1);
        tick();
        check("row_done_off", row_done, 0);
        check("busy_idle", busy, 0);
      end
    end
    check("start_count", start_cnt - s0, nwin);
    check("row_count", row_cnt - r0, 1);
    check("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    #1;
    do_reset();
    mon_en = 1'b1;
    check("rst_state", dbg_state, IDLE);
    check("rst_ready", s_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_round", round, 0);
    check("rst_adrs", {adrs_in1, adrs_in2}, 0);

    run_row(1, 0, 1'b0);
    run_row(3, 0, 1'b0);
    run_row(1, 2, 1'b0);
    run_row(2, 2, 1'b0);
    run_row(3, 0, 1'b1);

    // reset in the middle of a full load
    cfg_windows = CW'(1);
    cmd_start = 1'b1;
    tick();
    cmd_start = 1'b0;
    send_beats(25, 6, 0, 0);
    s_data  = 32'hdead_beef;
    s_valid = 1'b1;
    nrst    = 1'b1;
    tick();
    check("mid_rst_outs", {s_ready, start, round, wr_en, busy, row_done}, 0);
    check("mid_rst_data", {adrs_in1, adrs_in2, new1, new2}, 0);
    check("mid_rst_state", dbg_state, IDLE);
    nrst = 1'b0;
    repeat (4) tick();
    check("mid_rst_no_wr", exp_q.size(), 0);
    s_valid = 1'b0;
    tick();
    run_row(1, 0, 1'b0);

    run_row(0, 1, 1'b0);

    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pu_loader.md
# pu_loader

Upstream feeder for the img2col processing unit. Accepts a two-word-per-beat pixel stream with a valid/ready handshake and converts each beat into paired register-file writes: `new1`/`new2` data plus `adrs_in1`/`adrs_in2` addresses. It sequences one image row as a series of K×K windows. The first window of a row is a full load (`round`=0); each later window loads only the new K-word column (`round`=1). Between windows it waits for the PU to signal completion.

## Interface
- `DATA_WIDTH`, 16, pixel word width
- `KERNEL`, 5, window side K; window holds K*K words
- `ADDRESS_NUM`, 5, address width; must satisfy 2^ADDRESS_NUM ≥ K*K
- `CNT_WIDTH`, 16, width of the window counter
- `clk`  in  1  clock
- `nrst`  in  1  reset; synchronous and active-high (port name retained)
- `cmd_start`  in  1  one-cycle pulse; begins a row; ignored unless IDLE
- `cfg_windows`  in  CNT_WIDTH  windows per row; sampled on `cmd_start`; 0 treated as 1
- `s_valid`  in  1  stream beat valid
- `s_ready`  out  1  stream beat accepted when `s_valid`&&`s_ready`
- `s_data`  in  2*DATA_WIDTH  [DATA_WIDTH-1:0]=word A, upper half=word B
- `pu_done`  in  1  PU finished consuming current window
- `start`  out  1  one-cycle pulse at window begin
- `round`  out  1  0 = full load, 1 = column refill
- `wr_en`  out  1  `new1`/`new2` write valid this cycle
- `adrs_in1`, `adrs_in2`  out  ADDRESS_NUM  write addresses
- `new1`, `new2`  out  DATA_WIDTH  write data
- `busy`  out  1  state ≠ IDLE
- `row_done`  out  1  one-cycle pulse after last window's `pu_done`

## Operation
- FSM states:
  - IDLE: on `cmd_start` → LOAD; latch `cfg_windows`, window index=0.
  - LOAD: `s_ready`=1; accept beats until the window word count is reached → WAIT.
  - WAIT: on `pu_done`, if index=last → DONE, else index++ and → LOAD.
  - DONE: one cycle, `row_done`=1 → IDLE.
- Window word count N: K*K when index=0 (`round`=0); K otherwise (`round`=1).
- Base address: 0 for a full load; K*K−K for a refill (column written at top K addresses).
- Beat j of a window:
  - `adrs_in1`=base+2j, `adrs_in2`=base+2j+1, `new1`=word A, `new2`=word B.
  - Beats per window = ceil(N/2).
  - Odd N, final beat: word B discarded; `adrs_in2`=`adrs_in1`, `new2`=`new1` (duplicate benign write).
- `pu_done` outside WAIT is ignored; `cmd_start` outside IDLE is ignored.
- Address arithmetic is ADDRESS_NUM bits, never wraps for legal K.

## Timing
- Reset values: `s_ready`=0, `start`=0, `round`=0, `wr_en`=0, addresses=0, data=0, `busy`=0, `row_done`=0; state IDLE; counters 0.
- Synchronous reset takes priority over all events, including mid-LOAD. Partially loaded window is abandoned and no further writes are issued.
- `start` and `round`: registered. `start` pulses in the first LOAD cycle of each window; `round` holds its value for the whole window through WAIT.
- Handshake beat accepted at edge t → `wr_en`, addresses and data valid in cycle t+1 (one-cycle registered latency). `wr_en` is 0 otherwise.
- Back-to-back beats: one write per cycle, no bubbles.
- `s_ready` drops combinationally-free: registered, cleared in the cycle after the final beat is accepted. Final beat and LOAD→WAIT occur on the same edge.
- `pu_done` in WAIT → LOAD next cycle: `s_ready`=1 and `start`=1 in that cycle.
- `pu_done` coincident with `cmd_start`: `cmd_start` is ignored (not IDLE).

## Configuration
- `PU_LOADER_PERF_EN`: when defined, adds output `stall_cnt` [31:0].
  - Counts LOAD cycles with `s_valid`=0.
  - Cleared on reset and on `cmd_start`, saturating.
- Without the macro: the port and counter are absent; behaviour is otherwise identical.

## Structure
- Shared package `img2col_pkg`:
  - loader state enum `loader_state_t` (IDLE, LOAD, WAIT, DONE).
  - constants `K_DEFAULT`=5, `WIN_WORDS`=K*K, `REFILL_BASE`=K*K−K.
- One sub-module `pu_adrs_gen`: given round, beat index and last-beat flag, produces `adrs_in1`/`adrs_in2` and the odd-tail select.
- FSM, counters and output registers live in `pu_loader`.

## Test plan
- Full load, `cfg_windows`=1, continuous `s_valid`:
  - 13 writes; addresses (0,1)…(22,23), final (24,24) with `new2`=`new1`.
  - `start` once, `round`=0; `row_done` one cycle after `pu_done`.
- `cfg_windows`=3:
  - window 0 takes 13 beats; windows 1 and 2 take 3 beats each.
  - window 1/2 addresses (20,21),(22,23),(24,24); `round`=1; `start` pulses 3 times.
- Gapped `s_valid` (valid every third cycle):
  - writes appear exactly one cycle after each handshake; no extra `wr_en`.
  - with `PU_LOADER_PERF_EN`, `stall_cnt`=2 per accepted beat.
- `pu_done` held high during LOAD and `cmd_start` pulsed during WAIT:
  - both are ignored; window progression is unchanged.
- Reset asserted after beat 6 of a full load:
  - all outputs return to reset values next cycle; no further `wr_en`.
  - a subsequent `cmd_start` restarts at address 0.
- `cfg_windows`=0: behaves as 1 window; single `row_done`.
